// File: rtl/eth_pkg.sv
// Ethernet framing constants and builder state type,
// shared by the tx frame builder and the rx frame parser.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam int          ETH_HDR_LEN     = 14;
  localparam int          ETH_FCS_LEN     = 4;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_PAD,
    S_FCS,
    S_IFG
  } fb_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte,
// LSB first; no init or final XOR applied here.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0])
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/frame_builder.sv
// Ethernet tx frame serializer: preamble, header, streamed payload,
// zero pad, FCS and inter-frame gap onto an 8-bit port.
module frame_builder
  import eth_pkg::*;
#(
  parameter int PREAMBLE_EN = 0,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        err_underrun,
  output logic        err_oversize
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);
  localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);
  localparam logic [10:0] FCS_LAST = 11'(ETH_FCS_LEN - 1);

  fb_state_e    state, state_n;
  logic [10:0]  idx, idx_n;
  logic [10:0]  cnt, cnt_n;
  logic [111:0] hdr;
  logic [31:0]  crc, crc_src, crc_upd, fcs;
  logic [6:0]   hdr_pos;
  logic [7:0]   byte_n;
  logic         vld_n, crc_en, ld_hdr;
  logic         done_n, urun_n, ovsz_n;

  assign pl_ready = (state == S_PAY);
  assign busy     = (state != S_IDLE);
  assign fcs      = ~crc;
  assign hdr_pos  = 7'd104 - {idx[3:0], 3'b000};
  // the first header byte is hashed in the start cycle
  assign crc_src  = (state == S_IDLE) ? CRC32_INIT : crc;

  crc32_d8 u_crc (
    .crc_in  (crc_src),
    .data    (byte_n),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    byte_n  = 8'h00;
    vld_n   = 1'b0;
    crc_en  = 1'b0;
    ld_hdr  = 1'b0;
    done_n  = 1'b0;
    urun_n  = 1'b0;
    ovsz_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          ld_hdr = 1'b1;
          vld_n  = 1'b1;
          idx_n  = 11'd1;
          cnt_n  = '0;
          if (PREAMBLE_EN != 0) begin
            byte_n  = ETH_PREAMBLE;
            state_n = S_PRE;
          end else begin
            byte_n  = dest_mac[47:40];
            crc_en  = 1'b1;
            state_n = S_HDR;
          end
        end
      end
      S_PRE: begin
        vld_n = 1'b1;
        if (idx == 11'd7) begin
          byte_n  = ETH_SFD;
          idx_n   = '0;
          state_n = S_HDR;
        end else begin
          byte_n = ETH_PREAMBLE;
          idx_n  = idx + 11'd1;
        end
      end
      S_HDR: begin
        vld_n  = 1'b1;
        crc_en = 1'b1;
        byte_n = hdr[hdr_pos +: 8];
        if (idx == HDR_LAST) begin
          idx_n   = '0;
          state_n = S_PAY;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      S_PAY: begin
        if (pl_valid) begin
          vld_n  = 1'b1;
          crc_en = 1'b1;
          byte_n = pl_data;
          cnt_n  = cnt + 11'd1;
          if (pl_last) begin
            state_n = (cnt_n < MIN_CNT) ? S_PAD : S_FCS;
          end else if (cnt_n == MAX_CNT) begin
            ovsz_n  = 1'b1;
            state_n = S_FCS;
          end
        end else begin
          // abort without FCS so the receiver drops the frame
          urun_n  = 1'b1;
          idx_n   = '0;
          state_n = S_IFG;
        end
      end
      S_PAD: begin
        vld_n  = 1'b1;
        crc_en = 1'b1;
        cnt_n  = cnt + 11'd1;
        if (cnt_n == MIN_CNT) state_n = S_FCS;
      end
      S_FCS: begin
        vld_n  = 1'b1;
        byte_n = fcs[{idx[1:0], 3'b000} +: 8];
        if (idx == FCS_LAST) begin
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = S_IFG;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      S_IFG: begin
        if (idx == IFG_LAST) begin
          idx_n   = '0;
          state_n = S_IDLE;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      hdr          <= '0;
      crc          <= CRC32_INIT;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      tx_data      <= byte_n;
      tx_valid     <= vld_n;
      done         <= done_n;
      err_underrun <= urun_n;
      err_oversize <= ovsz_n;
      if (ld_hdr) hdr <= {dest_mac, src_mac, eth_type};
      if (crc_en)
        crc <= crc_upd;
      else if (state == S_IDLE)
        crc <= CRC32_INIT;
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Randomized bench for frame_builder against a queue-based frame model
// with a table-driven CRC-32.
module tb_frame_builder;
  import eth_pkg::*;

  localparam int MINP = 46;
  localparam int MAXP = 1500;
  localparam int IFG  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sel, pl_valid, pl_last;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [7:0]  pl_data;
  logic        start0, start1;
  logic [7:0]  txd0, txd1;
  logic        txv0, txv1, busy0, busy1, done0, done1;
  logic        eu0, eu1, eo0, eo1, rdy0, rdy1;
  logic [7:0]  o_txd;
  logic        o_txv, o_busy, o_done, o_eu, o_eo, o_rdy;
  logic [31:0] ut_crc, ut_out;
  logic [7:0]  ut_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_tab [256];
  logic [7:0]  pay_q[$], rx[$], exp_q[$], fcs_ref[$];
  int done_cnt, done_bad, eu_cnt, eu_valid, eo_cnt, eo_at;
  int rdy_late, gaps, ifg_len, after_end, mism, first_bad;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign o_txd  = sel ? txd1 : txd0;
  assign o_txv  = sel ? txv1 : txv0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_eu   = sel ? eu1 : eu0;
  assign o_eo   = sel ? eo1 : eo0;
  assign o_rdy  = sel ? rdy1 : rdy0;

  frame_builder #(.PREAMBLE_EN(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(rdy0), .tx_data(txd0), .tx_valid(txv0), .busy(busy0),
    .done(done0), .err_underrun(eu0), .err_oversize(eo0)
  );

  frame_builder #(.PREAMBLE_EN(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(rdy1), .tx_data(txd1), .tx_valid(txv1), .busy(busy1),
    .done(done1), .err_underrun(eu1), .err_oversize(eo1)
  );

  crc32_d8 u_crc (.crc_in(ut_crc), .data(ut_data), .crc_out(ut_out));

  function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] d);
    return (c >> 8) ^ crc_tab[c[7:0] ^ d];
  endfunction

  function automatic logic [31:0] residue(int from);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = from; i < rx.size(); i++) c = crc_step(c, rx[i]);
    return c;
  endfunction

  function automatic void fill_pay(int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endfunction

  // Run one frame from pay_q; expected bytes built from framing rules.
  task automatic run_frame(input logic s, input logic [47:0] d,
                           input logic [47:0] sm, input logic [15:0] t,
                           input bit use_last, input int urun_at,
                           input int hold);
    int pidx = 0;
    int end_cyc = -1;
    int last_v = -2;
    int n, na;
    bit ended = 0;
    bit xfer;
    logic [111:0] hdr;
    logic [31:0] c;
    n = pay_q.size();
    exp_q.delete();
    if (s) begin
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    hdr = {d, sm, t};
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(hdr[111-8*i -: 8]);
      c = crc_step(c, hdr[111-8*i -: 8]);
    end
    na = (urun_at > 0) ? urun_at : (use_last ? n : MAXP);
    for (int i = 0; i < na; i++) begin
      exp_q.push_back(pay_q[i]);
      c = crc_step(c, pay_q[i]);
    end
    if (urun_at == 0) begin
      for (int i = na; i < MINP; i++) begin
        exp_q.push_back(8'h00);
        c = crc_step(c, 8'h00);
      end
      c = c ^ 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end

    sel = s; dest_mac = d; src_mac = sm; eth_type = t;
    rx.delete();
    done_cnt = 0; done_bad = 0; eu_cnt = 0; eu_valid = 0;
    eo_cnt = 0; eo_at = -1; rdy_late = 0; gaps = 0;
    ifg_len = -1; after_end = 0;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      start    = (cyc < hold);
      pl_valid = (pidx < n) && !(urun_at > 0 && pidx >= urun_at);
      pl_data  = (pidx < n) ? pay_q[pidx] : 8'h00;
      pl_last  = use_last && (pidx == n - 1);
      @(negedge clk);
      if (o_txv) begin
        if (end_cyc >= 0) after_end++;
        else begin
          if (rx.size() > 0 && last_v != cyc - 1) gaps++;
          rx.push_back(o_txd);
          last_v = cyc;
        end
      end
      if (o_done) begin
        done_cnt++;
        if (!o_txv) done_bad++;
        end_cyc = cyc;
      end
      if (o_eu) begin
        eu_cnt++;
        if (o_txv) eu_valid++;
        end_cyc = cyc;
      end
      if (o_eo) begin
        eo_cnt++;
        eo_at = pidx;
      end
      if (eo_cnt > 0 && o_rdy) rdy_late++;
      if (end_cyc >= 0 && !o_busy) begin
        ifg_len = cyc - end_cyc;
        ended = 1;
      end
      xfer = o_rdy && pl_valid;
      @(posedge clk); #1;
      if (xfer) pidx++;
    end
    start = 1'b0; pl_valid = 1'b0; pl_last = 1'b0;
    if (!ended) begin
      checks++; errors++;
      $display("FAIL frame_timeout: frame did not end, bytes=%0d", rx.size());
    end
    mism = 0; first_bad = -1;
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
      if (rx[i] !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
    dest_mac = '0; src_mac = '0; eth_type = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({txd0, txv0, busy0, done0, eu0, eo0, rdy0} !== 14'h0) begin
      errors++;
      $display("FAIL reset_dut0: got %h want 0",
               {txd0, txv0, busy0, done0, eu0, eo0, rdy0});
    end
    checks++;
    if ({txd1, txv1, busy1, done1, eu1, eo1, rdy1} !== 14'h0) begin
      errors++;
      $display("FAIL reset_dut1: got %h want 0",
               {txd1, txv1, busy1, done1, eu1, eo1, rdy1});
    end
  endtask

  task automatic test_crc_unit();
    string s = "123456789";
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) begin
      ut_crc = c; ut_data = s[i];
      #1 c = ut_out;
    end
    checks++;
    if ((c ^ 32'hFFFFFFFF) !== 32'hCBF43926) begin
      errors++;
      $display("FAIL crc_check: got %h want cbf43926", c ^ 32'hFFFFFFFF);
    end
  endtask

  task automatic test_arp_frame();
    fill_pay(28);
    run_frame(1'b0, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 1, 0, 1);
    checks++;
    if (rx.size() != 64) begin
      errors++; $display("FAIL arp_len: got %0d want 64", rx.size());
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL arp_bytes: %0d wrong, first at %0d", mism, first_bad);
    end
    checks++;
    if (gaps != 0 || done_cnt != 1 || done_bad != 0) begin
      errors++;
      $display("FAIL arp_done: gaps=%0d done=%0d want 0/1", gaps, done_cnt);
    end
    checks++;
    if (residue(0) !== CRC32_RESIDUE) begin
      errors++;
      $display("FAIL arp_residue: got %h want debb20e3", residue(0));
    end
    checks++;
    if (ifg_len != IFG || after_end != 0) begin
      errors++;
      $display("FAIL arp_ifg: got %0d (valid %0d) want %0d (0)",
               ifg_len, after_end, IFG);
    end
  endtask

  task automatic test_preamble();
    logic [47:0] d = {16'h0A0B, 32'($urandom)};
    logic [47:0] sm = {16'h0200, 32'($urandom)};
    logic [15:0] t = 16'h0800;
    fill_pay(46);
    run_frame(1'b1, d, sm, t, 1, 0, 1);
    fcs_ref.delete();
    for (int i = rx.size() - 4; i >= 0 && i < rx.size(); i++)
      fcs_ref.push_back(rx[i]);
    checks++;
    if (rx.size() != 72 || mism != 0) begin
      errors++;
      $display("FAIL pre_frame: len %0d bad %0d want 72 0", rx.size(), mism);
    end
    checks++;
    if (done_cnt != 1 || gaps != 0) begin
      errors++;
      $display("FAIL pre_done: got %0d want 1", done_cnt);
    end
    run_frame(1'b0, d, sm, t, 1, 0, 1);
    checks++;
    if (rx.size() != 64 || fcs_ref.size() != 4 ||
        {rx[60], rx[61], rx[62], rx[63]} !==
        {fcs_ref[0], fcs_ref[1], fcs_ref[2], fcs_ref[3]}) begin
      errors++;
      $display("FAIL pre_fcs: len %0d, fcs differs from non-preamble frame",
               rx.size());
    end
  endtask

  task automatic test_random_frames();
    int lens[6] = '{1, 45, 46, 47, 100, 0};
    int n;
    logic s;
    lens[5] = $urandom_range(2, 200);
    for (int k = 0; k < 6; k++) begin
      n = lens[k];
      s = 1'($urandom_range(0, 1));
      fill_pay(n);
      run_frame(s, {$urandom, $urandom}, {$urandom, $urandom},
                16'($urandom), 1, 0, 1);
      checks++;
      if (rx.size() != exp_q.size() || mism != 0 || gaps != 0 ||
          done_cnt != 1 || eo_cnt != 0 || eu_cnt != 0) begin
        errors++;
        $display("FAIL rand_len%0d: len %0d bad %0d done %0d want %0d 0 1",
                 n, rx.size(), mism, done_cnt, exp_q.size());
      end
    end
  endtask

  task automatic test_underrun();
    fill_pay(30);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              16'h88B5, 1, 10, 1);
    checks++;
    if (eu_cnt != 1 || eu_valid != 0) begin
      errors++;
      $display("FAIL urun_pulse: got %0d (valid %0d) want 1 (0)",
               eu_cnt, eu_valid);
    end
    checks++;
    if (done_cnt != 0 || rx.size() != 24 || mism != 0) begin
      errors++;
      $display("FAIL urun_frame: done %0d len %0d want 0 24",
               done_cnt, rx.size());
    end
    checks++;
    if (ifg_len != IFG || after_end != 0) begin
      errors++;
      $display("FAIL urun_ifg: got %0d want %0d", ifg_len, IFG);
    end
  endtask

  task automatic test_oversize();
    fill_pay(1600);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              16'h86DD, 0, 0, 1);
    checks++;
    if (eo_cnt != 1 || eo_at != MAXP) begin
      errors++;
      $display("FAIL ovsz_pulse: count %0d at %0d want 1 at %0d",
               eo_cnt, eo_at, MAXP);
    end
    checks++;
    if (rdy_late != 0) begin
      errors++; $display("FAIL ovsz_ready: got %0d want 0", rdy_late);
    end
    checks++;
    if (rx.size() != 1518 || mism != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL ovsz_frame: len %0d bad %0d want 1518 0",
               rx.size(), mism);
    end
    checks++;
    if (residue(0) !== CRC32_RESIDUE) begin
      errors++;
      $display("FAIL ovsz_residue: got %h want debb20e3", residue(0));
    end
    fill_pay(MAXP);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              16'h0800, 1, 0, 1);
    checks++;
    if (eo_cnt != 0 || rx.size() != 1518 || mism != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL max_last: eo %0d len %0d want 0 1518",
               eo_cnt, rx.size());
    end
  endtask

  task automatic test_start_held();
    int bad = 0;
    fill_pay(20);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              16'h0800, 1, 0, 30);
    checks++;
    if (rx.size() != 64 || mism != 0 || after_end != 0) begin
      errors++;
      $display("FAIL held_frame: len %0d bad %0d want 64 0",
               rx.size(), mism);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_txv || o_busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL held_idle: got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    sel = 1'b0;
    dest_mac = {$urandom, $urandom}; src_mac = {$urandom, $urandom};
    eth_type = 16'h0800;
    pl_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20 && seen < 5; k++) begin
      @(negedge clk);
      if (o_txv) seen++;
    end
    checks++;
    if (seen != 5) begin
      errors++; $display("FAIL rst_setup: got %0d bytes want 5", seen);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_txv, o_busy, o_done, o_eu, o_eo} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid: got %b want 00000",
               {o_txv, o_busy, o_done, o_eu, o_eo});
    end
    reset = 1'b0;
    fill_pay(50);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              16'h0806, 1, 0, 1);
    checks++;
    if (rx.size() != 68 || mism != 0 || done_cnt != 1 ||
        residue(0) !== CRC32_RESIDUE) begin
      errors++;
      $display("FAIL rst_after: len %0d bad %0d want 68 0",
               rx.size(), mism);
    end
  endtask

  initial begin
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    ut_crc = '0; ut_data = '0;
    test_reset();
    test_crc_unit();
    test_arp_frame();
    test_preamble();
    test_random_frames();
    test_underrun();
    test_oversize();
    test_start_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
